// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store memory port.
//   size_e    - access size encodings (byte / half / word / illegal)
//   state_e   - request FSM states
//   lane_mask - byte-lane write-enable mask for a size and byte offset
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] addr_lo);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << addr_lo;
         SZ_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for the load/store port.
// Ports:
//   size      in  2   access size (lsu_pkg::size_e encoding)
//   addr_lo   in  2   byte offset within the word (already aligned as needed)
//   uns       in  1   zero-extend loads when 1
//   wdata     in  32  right-aligned store data
//   rdata     in  32  raw SRAM read word
//   lane_we   out 4   byte-lane enables for a store
//   wdata_rep out 32  store data replicated across all lanes
//   rdata_ext out 32  load data shifted down and sign/zero extended
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        uns,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  lane_we,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   always_comb begin
      lane_we   = lane_mask(size_e'(size), addr_lo);
      shifted   = rdata >> {addr_lo, 3'b000};
      wdata_rep = wdata;
      rdata_ext = shifted;
      case (size_e'(size))
         SZ_BYTE: begin
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = uns ? {24'h000000, shifted[7:0]}
                            : {{24{shifted[7]}}, shifted[7:0]};
         end
         SZ_HALF: begin
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = uns ? {16'h0000, shifted[15:0]}
                            : {{16{shifted[15]}}, shifted[15:0]};
         end
         default: begin
            wdata_rep = wdata;
            rdata_ext = shifted;
         end
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store adapter between the core's
// byte-addressed request channel and one port of the data SRAM.
// Optional build macro: LSU_MISALIGN_EXC_EN - when defined, misaligned half
// and word accesses are rejected with rsp_err; otherwise they are forced
// aligned by clearing the ignored low address bits.
// Ports:
//   clock, resetn            clock (rising edge), async active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_addr, req_size, req_unsigned, req_wdata  request fields
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       extended load data / illegal-access flag
//   mem_addr, mem_wdata, mem_we  SRAM word address, data, byte enables
//   mem_rdata                SRAM read data, one cycle after mem_addr
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int NBITS  = 32,
   parameter int LENGTH = 8192,
   parameter int AW     = $clog2(LENGTH/4)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [31:0]      req_addr,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [NBITS-1:0] req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [NBITS-1:0] rsp_rdata,
   output logic             rsp_err,
   output logic [AW-1:0]    mem_addr,
   output logic [NBITS-1:0] mem_wdata,
   output logic [3:0]       mem_we,
   input  logic [NBITS-1:0] mem_rdata
);

   localparam int LOG_LEN = $clog2(LENGTH);

   state_e           state_q, state_d;
   logic [AW+1:0]    addr_q;
   logic [1:0]       size_q;
   logic             we_q;
   logic             uns_q;
   logic [NBITS-1:0] wdata_q;

   logic             accept;
   logic             capture;
   logic             rsp_done;
   logic             oor;
   logic             illegal;
   logic [AW+1:0]    addr_fix;

   logic [3:0]       lane_we;
   logic [NBITS-1:0] wdata_rep;
   logic [NBITS-1:0] rdata_ext;

   // Request legality and the effective (possibly force-aligned) address.
   always_comb begin
      oor      = (req_addr >> LOG_LEN) != 32'd0;
      addr_fix = req_addr[AW+1:0];
`ifdef LSU_MISALIGN_EXC_EN
      illegal  = (size_e'(req_size) == SZ_ILL) || oor
              || ((size_e'(req_size) == SZ_HALF) && req_addr[0])
              || ((size_e'(req_size) == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
      illegal  = (size_e'(req_size) == SZ_ILL) || oor;
      if (size_e'(req_size) == SZ_HALF) begin
         addr_fix[0] = 1'b0;
      end else if (size_e'(req_size) == SZ_WORD) begin
         addr_fix[1:0] = 2'b00;
      end
`endif
   end

   // One steering block serves both the ISSUE (store lanes) and WAIT
   // (load extract) paths, since only one request is ever in flight.
   lsu_align u_align (
      .size      (size_q),
      .addr_lo   (addr_q[1:0]),
      .uns       (uns_q),
      .wdata     (wdata_q),
      .rdata     (mem_rdata),
      .lane_we   (lane_we),
      .wdata_rep (wdata_rep),
      .rdata_ext (rdata_ext)
   );

   assign mem_addr = addr_q[AW+1:2];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // mem_we is decoded from the state register rather than registered, so an
   // asynchronous reset during ISSUE removes the write enable immediately.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_we    = '0;
      mem_wdata = '0;
      accept    = 1'b0;
      capture   = 1'b0;
      rsp_done  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = illegal ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               mem_we    = lane_we;
               mem_wdata = wdata_rep;
               state_d   = ST_RESP;
            end else begin
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            capture = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               rsp_done = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         addr_q    <= '0;
         size_q    <= '0;
         we_q      <= 1'b0;
         uns_q     <= 1'b0;
         wdata_q   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            rsp_rdata <= '0;
            rsp_err   <= illegal;
            // An illegal request leaves the SRAM-side registers untouched.
            if (!illegal) begin
               addr_q  <= addr_fix;
               size_q  <= req_size;
               we_q    <= req_we;
               uns_q   <= req_unsigned;
               wdata_q <= req_wdata;
            end
         end
         if (capture) begin
            rsp_rdata <= rdata_ext;
         end
         if (rsp_done) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

   localparam int LENGTH = 8192;
   localparam int AW     = $clog2(LENGTH/4);
   localparam int WORDS  = LENGTH/4;
`ifdef LSU_MISALIGN_EXC_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [31:0]   req_addr = '0;
   logic [1:0]    req_size = '0;
   logic          req_unsigned = 1'b0;
   logic [31:0]   req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_we;
   logic [31:0]   mem_rdata;

   lsu_mem_port #(.NBITS(32), .LENGTH(LENGTH)) dut (
      .clock        (clock),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_rdata    (mem_rdata)
   );

   always #5 clock = ~clock;

   // SRAM port with registered read.
   logic [31:0] sram [WORDS] = '{default: 32'h0};
   always @(posedge clock) begin
      for (int k = 0; k < 4; k++)
         if (mem_we[k]) sram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      mem_rdata <= sram[mem_addr];
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Reference memory as a flat byte array.
   byte unsigned ref_mem [LENGTH];

   typedef struct {
      bit        we;
      bit [31:0] addr;
      bit [1:0]  size;
      bit        uns;
      bit [31:0] wdata;
      int        hold;
      bit        err;
      bit [31:0] rdata;
      int        lat;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_word(input int idx);
      return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
   endfunction

   // Behavioural model: legality, effective address, byte-wise memory effect.
   task automatic model(input bit we, input bit [31:0] addr, input bit [1:0] size,
                        input bit uns, input bit [31:0] wdata,
                        output bit err, output bit [31:0] rd, output int lat,
                        output bit [3:0] mask, output int waddr, output bit [31:0] wrep);
      int unsigned nb;
      int unsigned eff;
      bit [63:0]   v;
      err = 0; rd = 0; lat = 0; mask = 0; waddr = 0; wrep = 0;
      if (size == 2'd3 || addr >= LENGTH) begin
         err = 1; lat = 1; return;
      end
      nb = 1 << size;
      if (MIS && (addr % nb) != 0) begin
         err = 1; lat = 1; return;
      end
      eff   = addr - (addr % nb);
      waddr = int'(eff / 4);
      if (we) begin
         for (int i = 0; i < int'(nb); i++) ref_mem[eff + i] = wdata[8*i +: 8];
         mask = 4'(((1 << nb) - 1) << (eff % 4));
         for (int k = 0; k < 4; k++) wrep[8*k +: 8] = wdata[8*(k % nb) +: 8];
         lat = 2;
      end else begin
         v = 0;
         for (int i = 0; i < int'(nb); i++) v = v | (64'(ref_mem[eff + i]) << (8*i));
         if (!uns && nb < 4 && v[8*nb-1]) v = v | (64'hFFFF_FFFF << (8*nb));
         rd  = v[31:0];
         lat = 3;
      end
   endtask

   task automatic txn(input bit we, input bit [31:0] addr, input bit [1:0] size,
                      input bit uns, input bit [31:0] wdata, input int hold,
                      input bit use_tab, input bit t_err, input bit [31:0] t_rd, input int t_lat);
      bit        m_err, e_err;
      bit [31:0] m_rd, e_rd, m_wrep;
      int        m_lat, e_lat, waddr, lat, nz, n;
      bit [3:0]  m_mask;
      logic [3:0]    o_mask;
      logic [31:0]   o_wd, rd0;
      logic [AW-1:0] ma1;
      logic          err0;
      model(we, addr, size, uns, wdata, m_err, m_rd, m_lat, m_mask, waddr, m_wrep);
      if (use_tab) begin e_err = t_err; e_rd = t_rd; e_lat = t_lat; end
      else begin e_err = m_err; e_rd = m_rd; e_lat = m_lat; end

      n = 0;
      while (!req_ready && n < 10) begin @(negedge clock); n++; end
      if (!req_ready) begin
         chk("req_ready_before_req", req_ready, 1);
         return;
      end
      req_valid = 1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wdata;
      @(posedge clock);
      #1 req_valid = 0;

      lat = 0; nz = 0; o_mask = 0; o_wd = 0; ma1 = 0;
      do begin
         @(negedge clock);
         lat++;
         if (lat == 1) ma1 = mem_addr;
         if (mem_we != 4'b0000) begin nz++; o_mask = mem_we; o_wd = mem_wdata; end
      end while (!rsp_valid && lat < 20);
      if (!rsp_valid) begin
         chk("rsp_valid_timeout", rsp_valid, 1);
         return;
      end
      chk("latency", lat, e_lat);
      chk("rsp_err", rsp_err, e_err);
      chk("rsp_rdata", rsp_rdata, e_rd);
      chk("mem_we_cycles", nz, (we && !m_err) ? 1 : 0);
      if (!m_err) chk("mem_addr", 32'(ma1), waddr);
      if (we && !m_err) begin
         chk("mem_we_mask", o_mask, m_mask);
         chk("mem_wdata", o_wd, m_wrep);
      end

      rd0 = rsp_rdata; err0 = rsp_err;
      for (int h = 0; h < hold; h++) begin
         @(posedge clock);
         @(negedge clock);
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_rsp_rdata", rsp_rdata, rd0);
         chk("hold_rsp_err", rsp_err, err0);
         chk("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1;
      @(posedge clock);
      #1 rsp_ready = 0;
      @(negedge clock);
      chk("post_hs_req_ready", req_ready, 1);
      chk("post_hs_rsp_valid", rsp_valid, 0);
      if (we) chk("sram_word", sram[(addr % LENGTH) / 4], ref_word(int'((addr % LENGTH) / 4)));
   endtask

   function automatic vec_t mk(input bit we, input bit [31:0] addr, input bit [1:0] size,
                               input bit uns, input bit [31:0] wdata, input int hold,
                               input bit err, input bit [31:0] rdata, input int lat);
      vec_t v;
      v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
      v.hold = hold; v.err = err; v.rdata = rdata; v.lat = lat;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [31:0] ra;
      // ---- reset state
      repeat (2) @(negedge clock);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      resetn = 1;
      @(negedge clock);

      // ---- directed table
      vecs.push_back(mk(1, 32'h10, 2, 0, 32'hA1B2C3D4, 0, 0, 32'h0, 2));
      vecs.push_back(mk(0, 32'h10, 0, 0, 32'h0, 0, 0, 32'hFFFFFFD4, 3));
      vecs.push_back(mk(0, 32'h12, 1, 1, 32'h0, 0, 0, 32'h0000A1B2, 3));
      vecs.push_back(mk(0, 32'h12, 1, 0, 32'h0, 0, 0, 32'hFFFFA1B2, 3));
      vecs.push_back(mk(0, 32'h11, 0, 1, 32'h0, 0, 0, 32'h000000C3, 3));
      vecs.push_back(mk(0, 32'h11, 0, 0, 32'h0, 0, 0, 32'hFFFFFFC3, 3));
      vecs.push_back(mk(0, 32'h10, 1, 0, 32'h0, 0, 0, 32'hFFFFC3D4, 3));
      vecs.push_back(mk(0, 32'h11, 2, 0, 32'h0, 0, MIS, MIS ? 32'h0 : 32'hA1B2C3D4, MIS ? 1 : 3));
      vecs.push_back(mk(0, 32'h13, 1, 1, 32'h0, 0, MIS, MIS ? 32'h0 : 32'h0000A1B2, MIS ? 1 : 3));
      vecs.push_back(mk(1, 32'h13, 0, 0, 32'h0000005A, 0, 0, 32'h0, 2));
      vecs.push_back(mk(0, 32'h10, 2, 0, 32'h0, 3, 0, 32'h5AB2C3D4, 3));
      vecs.push_back(mk(0, 32'h13, 0, 0, 32'h0, 0, 0, 32'h0000005A, 3));
      vecs.push_back(mk(1, 32'h2000, 2, 0, 32'h11223344, 0, 1, 32'h0, 1));
      vecs.push_back(mk(1, 32'h10, 3, 0, 32'hFFFFFFFF, 0, 1, 32'h0, 1));
      vecs.push_back(mk(0, 32'h10, 2, 0, 32'h0, 0, 0, 32'h5AB2C3D4, 3));
      vecs.push_back(mk(1, 32'h1FFF, 0, 0, 32'h00000080, 0, 0, 32'h0, 2));
      vecs.push_back(mk(0, 32'h1FFF, 0, 0, 32'h0, 1, 0, 32'hFFFFFF80, 3));
      vecs.push_back(mk(0, 32'h1FFF, 0, 1, 32'h0, 0, 0, 32'h00000080, 3));
      vecs.push_back(mk(0, 32'hFFFFFFFC, 2, 0, 32'h0, 0, 1, 32'h0, 1));
      vecs.push_back(mk(1, 32'h1FFE, 1, 0, 32'hABCD1234, 0, 0, 32'h0, 2));
      vecs.push_back(mk(0, 32'h1FFC, 2, 0, 32'h0, 2, 0, 32'h12340000, 3));
      foreach (vecs[i])
         txn(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
             vecs[i].hold, 1, vecs[i].err, vecs[i].rdata, vecs[i].lat);

      // ---- reset pulsed during ISSUE of a word store
      req_valid = 1; req_we = 1; req_addr = 32'h20; req_size = 2;
      req_unsigned = 0; req_wdata = 32'hDEADBEEF;
      @(posedge clock);
      #1 req_valid = 0;
      @(negedge clock);
      chk("issue_mem_we", 32'(mem_we), 32'hF);
      resetn = 0;
      #1;
      chk("arst_mem_we", 32'(mem_we), 0);
      chk("arst_req_ready", req_ready, 1);
      chk("arst_rsp_valid", rsp_valid, 0);
      chk("arst_rsp_rdata", rsp_rdata, 0);
      chk("arst_rsp_err", rsp_err, 0);
      chk("arst_mem_addr", 32'(mem_addr), 0);
      chk("arst_mem_wdata", mem_wdata, 0);
      @(posedge clock);
      @(negedge clock);
      resetn = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         chk("arst_no_rsp", rsp_valid, 0);
      end
      chk("arst_sram_word8", sram[8], ref_word(8));

      // ---- randomized traffic against the model
      for (int t = 0; t < 200; t++) begin
         case ($urandom_range(0, 9))
            0: ra = $urandom;
            1, 2, 3, 4: ra = $urandom_range(0, 127);
            default: ra = $urandom_range(LENGTH - 128, LENGTH - 1);
         endcase
         txn(1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2), 0, 0, 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
